status_register_unit: RTL and testbench
=======================================

# status_register_unit

Producer side of the NZCV flag path. The unit owns the architectural status register, which is written by flag-setting instructions at the execute stage. It supplies the registered and forwarded flag values to the condition checker and tracks in-flight flag writers so the control unit can stall a conditional instruction in decode when its flags are not yet available. Flag layout matches the condition checker: N = bit 3, Z = bit 2, C = bit 1, V = bit 0.

## Interface
Parameters:
- `ISSUE_TO_EX`, default 1: pipeline register stages from decode issue to execute. Legal range is 1..4.
- `FWD_EN`, default 1: 1 enables the execute-to-decode flag bypass; 0 means the decode stage reads only the registered flags.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `hold`  in  1  global pipeline stall. Freezes every register in this unit.
- `flush`  in  1  kills every instruction younger than the one in execute, including the one in decode.
- `id_valid`  in  1  decode holds a real instruction.
- `id_sets_flags`  in  1  S bit of the decode instruction.
- `id_uses_flags`  in  1  decode condition is not AL.
- `exe_sr_we`  in  1  the execute-stage instruction writes flags this cycle.
- `exe_flags`  in  4  new NZCV from the ALU.
- `status_register`  out  4  architectural NZCV, registered.
- `status_fwd`  out  4  flags the decode condition check must use (combinational).
- `flag_hazard`  out  1  decode must stall (combinational).
- `inflight_count`  out  3  number of pending flag writers, 0..4.
- `protocol_err`  out  1  sticky error flag.

## Operation
- Reset values: `status_register` = 4'b0000, `pend` = 0, `protocol_err` = 0. Consequently `flag_hazard` = 0, `inflight_count` = 0, and `status_fwd` = `exe_flags` if `exe_sr_we` is high, else 4'b0000.
- The scoreboard is `pend[ISSUE_TO_EX-1:0]`, a shift register. `pend[ISSUE_TO_EX-1]` marks a flag writer currently in execute.
- `issue` = `id_valid` & `id_sets_flags` & ~`flag_hazard` & ~`flush` & ~`hold`.
- Scoreboard update, in priority order:
  1. `rst` clears everything.
  2. `hold` keeps all state.
  3. `flush` clears `pend`.
  4. Otherwise `pend` <= {`pend[ISSUE_TO_EX-2:0]`, `issue`}. When `ISSUE_TO_EX` = 1, this is `pend` <= `issue`.
- Status write: when `exe_sr_we` & ~`hold`, `status_register` <= `exe_flags`.
  - The write is not blocked by `flush`, because the execute instruction is older than the flush point.
- Forwarding:
  - `status_fwd` = `exe_sr_we` ? `exe_flags` : `status_register` when `FWD_EN` = 1.
  - `status_fwd` = `status_register` when `FWD_EN` = 0.
- Hazard:
  - With `FWD_EN` = 1: `flag_hazard` = `id_valid` & `id_uses_flags` & |`pend[ISSUE_TO_EX-2:0]`. It is constant 0 when `ISSUE_TO_EX` = 1.
  - With `FWD_EN` = 0: `flag_hazard` = `id_valid` & `id_uses_flags` & |`pend`.
  - `flag_hazard` is not gated by `hold` or `flush`; the control unit resolves that priority.
- `inflight_count` = popcount(`pend`), zero-extended to 3 bits.
- `protocol_err` is set, and remains set until `rst`, in either of these cases:
  - `exe_sr_we` & ~`hold` while `pend[ISSUE_TO_EX-1]` = 0. The write still happens.
  - `pend[ISSUE_TO_EX-1]` = 1 & ~`hold` & ~`exe_sr_we`. A flag writer left execute without writing.

## Timing
- Flag write latency: `exe_flags` appear on `status_register` one cycle after `exe_sr_we`, and on `status_fwd` in the same cycle.
- Decode to execute: an instruction issued at cycle t sets `pend[0]` at t+1 and is in execute (`pend[ISSUE_TO_EX-1]`) at t+`ISSUE_TO_EX`.
- Stall length with default parameters: never. With `FWD_EN` = 0 and `ISSUE_TO_EX` = 1, a dependent instruction stalls exactly 1 cycle.
- Back-to-back flag writers: each occupies its own `pend` bit, and the last write wins in `status_register`.
- Simultaneous `hold` and `exe_sr_we`: no write. The execute stage re-presents the write after `hold` drops.
- Simultaneous `flush` and `exe_sr_we`: the write happens, and `pend` clears next cycle.
- Reset mid-operation: state clears on the next edge and any pending writer is dropped. A post-reset `exe_sr_we` without issue sets `protocol_err`, so the bench must also reset the pipeline.

## Test plan
- **Reset.** Hold `rst` 2 cycles with `exe_sr_we`=1 and `exe_flags`=4'hF, then release with `exe_sr_we`=0. Required: `status_register`=0, `inflight_count`=0, `protocol_err`=0.
- **Write and forward** (default parameters). Issue a flag writer; next cycle drive `exe_sr_we`=1 and `exe_flags`=4'b0100. Required: `status_fwd`=4'b0100 in the same cycle, `status_register`=4'b0100 one cycle later, `flag_hazard` never asserted.
- **No-forward stall** (`FWD_EN`=0, `ISSUE_TO_EX`=1). Issue a writer, then a flag user. Required: `flag_hazard`=1 for exactly 1 cycle, and the user sees `status_register`=`exe_flags` of the writer.
- **Deep pipeline** (`ISSUE_TO_EX`=3, `FWD_EN`=1). Issue writers on 3 consecutive cycles. Required: `inflight_count` goes 1,2,3 and then holds 3 while issuing continues. A flag user is stalled until only the execute bit is set.
- **Flush and hold.** With 2 pending writers, pulse `flush` while `exe_sr_we`=1 and `exe_flags`=4'b1001. Required: `status_register`=4'b1001 and `inflight_count`=0 next cycle. Then `hold`=1 with `exe_sr_we`=1 and `exe_flags`=4'h3. Required: `status_register` stays 4'b1001.
- **Protocol error.** Assert `exe_sr_we` with `pend`=0 and `exe_flags`=4'b0010. Required: `status_register`=4'b0010, and `protocol_err`=1 until `rst`.

Source files
------------

// File: rtl/status_register_unit.sv
// status_register_unit
//   Owns the architectural NZCV status register (N=bit 3, Z=bit 2, C=bit 1, V=bit 0).
//   It forwards flags to the decode condition check and tracks in-flight flag
//   writers so that decode can be stalled until the flags it needs are available.
//
// Parameters
//   ISSUE_TO_EX : pipeline register stages from decode issue to execute (1..4)
//   FWD_EN      : 1 enables the execute-to-decode flag bypass
//
// Ports
//   clk, rst          : clock (rising edge) and synchronous active-high reset
//   hold              : global stall, freezes every register in this unit
//   flush             : kills everything younger than execute (decode included)
//   id_valid          : decode holds a real instruction
//   id_sets_flags     : decode instruction writes flags
//   id_uses_flags     : decode instruction reads flags (condition is not AL)
//   exe_sr_we         : execute-stage instruction writes flags this cycle
//   exe_flags         : new NZCV from the ALU
//   status_register   : architectural NZCV (registered)
//   status_fwd        : NZCV the decode condition check must use
//   flag_hazard       : decode must stall
//   inflight_count    : number of pending flag writers
//   protocol_err      : sticky error, execute write/scoreboard disagreement
module status_register_unit #(
    parameter int unsigned ISSUE_TO_EX = 1,
    parameter bit          FWD_EN      = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic       flush,
    input  logic       id_valid,
    input  logic       id_sets_flags,
    input  logic       id_uses_flags,
    input  logic       exe_sr_we,
    input  logic [3:0] exe_flags,
    output logic [3:0] status_register,
    output logic [3:0] status_fwd,
    output logic       flag_hazard,
    output logic [2:0] inflight_count,
    output logic       protocol_err
);

    localparam int unsigned N = ISSUE_TO_EX;

    logic [3:0]   status_q, status_d;
    logic [N-1:0] pend_q, pend_d;
    logic         err_q, err_d;

    logic         older_pend;
    logic         any_pend;
    logic         ex_pend;
    logic         issue;
    logic [2:0]   count;

    // Scoreboard views: writers still before execute, any writer, writer in execute.
    always_comb begin
        older_pend = 1'b0;
        for (int i = 0; i < int'(N) - 1; i++) begin
            older_pend = older_pend | pend_q[i];
        end
        any_pend = |pend_q;
        ex_pend  = pend_q[N-1];
    end

    // With the bypass, a writer already in execute is covered by status_fwd,
    // so only writers that have not yet reached execute cause a stall.
    always_comb begin
        flag_hazard = id_valid & id_uses_flags & (FWD_EN ? older_pend : any_pend);
        issue       = id_valid & id_sets_flags & ~flag_hazard & ~flush & ~hold;
    end

    always_comb begin
        pend_d = pend_q;
        if (!hold) begin
            if (flush) begin
                pend_d = '0;
            end else begin
                pend_d[0] = issue;
                for (int i = 1; i < int'(N); i++) begin
                    pend_d[i] = pend_q[i-1];
                end
            end
        end
    end

    // The execute instruction is older than any flush point, so flush does not
    // block the write.
    always_comb begin
        status_d = status_q;
        if (exe_sr_we && !hold) begin
            status_d = exe_flags;
        end
    end

    // Error: a write with no writer in execute, or a writer leaving execute
    // without writing.
    always_comb begin
        err_d = err_q;
        if (!hold && (exe_sr_we != ex_pend)) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < int'(N); i++) begin
            count = count + 3'(pend_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= 4'b0000;
            pend_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            status_q <= status_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        status_register = status_q;
        status_fwd      = (FWD_EN && exe_sr_we) ? exe_flags : status_q;
        inflight_count  = count;
        protocol_err    = err_q;
    end

endmodule

// File: tb/tb_status_register_unit.sv
// Bench for status_register_unit. Three instances cover the default
// configuration, the no-bypass single-stage case and a three-stage pipeline.
// A queue-based reference model tracks each in-flight writer by the advance
// count at which it issued.
module tb_status_register_unit;

    localparam int NI = 3;
    localparam int unsigned I2E [NI] = '{1, 1, 3};
    localparam bit          FWD [NI] = '{1'b1, 1'b0, 1'b1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst           [NI];
    logic       hold          [NI];
    logic       flush         [NI];
    logic       id_valid      [NI];
    logic       id_sets_flags [NI];
    logic       id_uses_flags [NI];
    logic       exe_sr_we     [NI];
    logic [3:0] exe_flags     [NI];
    logic [3:0] sr            [NI];
    logic [3:0] fwd           [NI];
    logic       haz           [NI];
    logic [2:0] cnt           [NI];
    logic       perr          [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        status_register_unit #(
            .ISSUE_TO_EX(I2E[g]),
            .FWD_EN     (FWD[g])
        ) u_dut (
            .clk            (clk),
            .rst            (rst[g]),
            .hold           (hold[g]),
            .flush          (flush[g]),
            .id_valid       (id_valid[g]),
            .id_sets_flags  (id_sets_flags[g]),
            .id_uses_flags  (id_uses_flags[g]),
            .exe_sr_we      (exe_sr_we[g]),
            .exe_flags      (exe_flags[g]),
            .status_register(sr[g]),
            .status_fwd     (fwd[g]),
            .flag_hazard    (haz[g]),
            .inflight_count (cnt[g]),
            .protocol_err   (perr[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [3:0]  m_sr  [NI];
    bit          m_err [NI];
    int unsigned m_adv [NI];
    int unsigned m_q   [NI][$];

    function automatic bit m_in_ex(input int k);
        for (int i = 0; i < m_q[k].size(); i++)
            if (m_adv[k] - m_q[k][i] == I2E[k]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_hazard(input int k);
        bit older = 1'b0;
        bit any   = 1'b0;
        for (int i = 0; i < m_q[k].size(); i++) begin
            any = 1'b1;
            if (m_adv[k] - m_q[k][i] < I2E[k]) older = 1'b1;
        end
        return id_valid[k] & id_uses_flags[k] & (FWD[k] ? older : any);
    endfunction

    function automatic logic [3:0] m_fwd(input int k);
        return (FWD[k] && exe_sr_we[k]) ? exe_flags[k] : m_sr[k];
    endfunction

    task automatic idle(input int k);
        rst[k] = 1'b0; hold[k] = 1'b0; flush[k] = 1'b0;
        id_valid[k] = 1'b0; id_sets_flags[k] = 1'b0; id_uses_flags[k] = 1'b0;
        exe_sr_we[k] = 1'b0; exe_flags[k] = 4'h0;
    endtask

    // One clock edge for instance k, advancing the model with the applied inputs.
    task automatic step(input int k);
        bit iss;
        bit in_ex;
        iss   = id_valid[k] & id_sets_flags[k] & ~m_hazard(k) & ~flush[k] & ~hold[k];
        in_ex = m_in_ex(k);
        @(posedge clk);
        if (rst[k]) begin
            m_sr[k] = 4'h0; m_err[k] = 1'b0; m_q[k].delete();
        end else if (!hold[k]) begin
            if (exe_sr_we[k]) m_sr[k] = exe_flags[k];
            if (exe_sr_we[k] != in_ex) m_err[k] = 1'b1;
            if (flush[k]) m_q[k].delete();
            else begin
                if (in_ex) void'(m_q[k].pop_front());
                if (iss) m_q[k].push_back(m_adv[k]);
            end
            m_adv[k]++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset(input int k);
        idle(k);
        rst[k] = 1'b1; exe_sr_we[k] = 1'b1; exe_flags[k] = 4'hF;
        step(k); step(k);
        rst[k] = 1'b0; exe_sr_we[k] = 1'b0;
        #1;
        n_cmp++; if (sr[k] !== 4'h0) begin n_bad++;
            $display("FAIL reset_status[%0d] got %h want 0", k, sr[k]); end
        n_cmp++; if (cnt[k] !== 3'd0) begin n_bad++;
            $display("FAIL reset_count[%0d] got %0d want 0", k, cnt[k]); end
        n_cmp++; if (perr[k] !== 1'b0) begin n_bad++;
            $display("FAIL reset_err[%0d] got %b want 0", k, perr[k]); end
        n_cmp++; if (fwd[k] !== 4'h0) begin n_bad++;
            $display("FAIL reset_fwd[%0d] got %h want 0", k, fwd[k]); end
    endtask

    task automatic test_write_forward();
        idle(0);
        id_valid[0] = 1'b1; id_sets_flags[0] = 1'b1;
        #1;
        n_cmp++; if (haz[0] !== 1'b0) begin n_bad++;
            $display("FAIL wf_hazard_issue got %b want 0", haz[0]); end
        step(0);
        id_sets_flags[0] = 1'b0; id_uses_flags[0] = 1'b1;
        exe_sr_we[0] = 1'b1; exe_flags[0] = 4'b0100;
        #1;
        n_cmp++; if (fwd[0] !== 4'b0100) begin n_bad++;
            $display("FAIL wf_fwd got %b want 0100", fwd[0]); end
        n_cmp++; if (haz[0] !== 1'b0) begin n_bad++;
            $display("FAIL wf_hazard_use got %b want 0", haz[0]); end
        step(0);
        idle(0);
        #1;
        n_cmp++; if (sr[0] !== 4'b0100) begin n_bad++;
            $display("FAIL wf_status got %b want 0100", sr[0]); end
        n_cmp++; if (perr[0] !== 1'b0) begin n_bad++;
            $display("FAIL wf_err got %b want 0", perr[0]); end
    endtask

    task automatic test_noforward_stall();
        idle(1);
        id_valid[1] = 1'b1; id_sets_flags[1] = 1'b1;
        #1;
        step(1);
        id_sets_flags[1] = 1'b0; id_uses_flags[1] = 1'b1;
        exe_sr_we[1] = 1'b1; exe_flags[1] = 4'b1010;
        #1;
        n_cmp++; if (haz[1] !== 1'b1) begin n_bad++;
            $display("FAIL nf_stall_first got %b want 1", haz[1]); end
        n_cmp++; if (fwd[1] !== 4'b0000) begin n_bad++;
            $display("FAIL nf_fwd_blocked got %b want 0000", fwd[1]); end
        step(1);
        exe_sr_we[1] = 1'b0;
        #1;
        n_cmp++; if (haz[1] !== 1'b0) begin n_bad++;
            $display("FAIL nf_stall_second got %b want 0", haz[1]); end
        n_cmp++; if (fwd[1] !== 4'b1010) begin n_bad++;
            $display("FAIL nf_user_flags got %b want 1010", fwd[1]); end
        step(1);
        idle(1);
    endtask

    task automatic test_deep();
        int stalls;
        idle(2);
        id_valid[2] = 1'b1; id_sets_flags[2] = 1'b1;
        for (int j = 0; j < 5; j++) begin
            exe_sr_we[2] = m_in_ex(2); exe_flags[2] = 4'($urandom);
            #1;
            n_cmp++; if (cnt[2] !== 3'((j < 3) ? j : 3)) begin n_bad++;
                $display("FAIL deep_count[%0d] got %0d want %0d", j, cnt[2], (j < 3) ? j : 3); end
            step(2);
        end
        id_sets_flags[2] = 1'b0; id_uses_flags[2] = 1'b1;
        stalls = 0;
        for (int j = 0; j < 6; j++) begin
            exe_sr_we[2] = m_in_ex(2); exe_flags[2] = 4'($urandom);
            #1;
            if (!haz[2]) break;
            stalls++;
            step(2);
        end
        n_cmp++; if (stalls != 2) begin n_bad++;
            $display("FAIL deep_stall_cycles got %0d want 2", stalls); end
        n_cmp++; if (cnt[2] !== 3'd1) begin n_bad++;
            $display("FAIL deep_release_count got %0d want 1", cnt[2]); end
        step(2);
        idle(2);
        #1;
        n_cmp++; if (perr[2] !== 1'b0) begin n_bad++;
            $display("FAIL deep_err got %b want 0", perr[2]); end
    endtask

    task automatic test_flush_hold();
        idle(2);
        id_valid[2] = 1'b1; id_sets_flags[2] = 1'b1;
        step(2); step(2);
        id_valid[2] = 1'b0;
        step(2);
        flush[2] = 1'b1; exe_sr_we[2] = 1'b1; exe_flags[2] = 4'b1001;
        #1;
        n_cmp++; if (cnt[2] !== 3'd2) begin n_bad++;
            $display("FAIL fh_pending got %0d want 2", cnt[2]); end
        step(2);
        flush[2] = 1'b0; hold[2] = 1'b1; exe_flags[2] = 4'h3;
        #1;
        n_cmp++; if (sr[2] !== 4'b1001) begin n_bad++;
            $display("FAIL fh_flush_write got %b want 1001", sr[2]); end
        n_cmp++; if (cnt[2] !== 3'd0) begin n_bad++;
            $display("FAIL fh_flush_count got %0d want 0", cnt[2]); end
        step(2);
        #1;
        n_cmp++; if (sr[2] !== 4'b1001) begin n_bad++;
            $display("FAIL fh_hold_write got %b want 1001", sr[2]); end
        idle(2);
        step(2);
        n_cmp++; if (perr[2] !== 1'b0) begin n_bad++;
            $display("FAIL fh_err got %b want 0", perr[2]); end
    endtask

    task automatic test_protocol_err();
        idle(0);
        exe_sr_we[0] = 1'b1; exe_flags[0] = 4'b0010;
        step(0);
        idle(0);
        for (int j = 0; j < 3; j++) begin
            #1;
            n_cmp++; if (perr[0] !== 1'b1) begin n_bad++;
                $display("FAIL pe_sticky[%0d] got %b want 1", j, perr[0]); end
            step(0);
        end
        n_cmp++; if (sr[0] !== 4'b0010) begin n_bad++;
            $display("FAIL pe_status got %b want 0010", sr[0]); end
        rst[0] = 1'b1;
        step(0);
        rst[0] = 1'b0;
        #1;
        n_cmp++; if (perr[0] !== 1'b0) begin n_bad++;
            $display("FAIL pe_cleared got %b want 0", perr[0]); end
    endtask

    task automatic test_random(input int k, input int cycles);
        idle(k);
        rst[k] = 1'b1;
        step(k);
        for (int j = 0; j < cycles; j++) begin
            rst[k]           = ($urandom_range(99) == 0);
            hold[k]          = ($urandom_range(7) == 0);
            flush[k]         = ($urandom_range(9) == 0);
            id_valid[k]      = 1'($urandom);
            id_sets_flags[k] = 1'($urandom);
            id_uses_flags[k] = 1'($urandom);
            exe_sr_we[k]     = m_in_ex(k) ^ ($urandom_range(63) == 0);
            exe_flags[k]     = 4'($urandom);
            #1;
            n_cmp++; if (sr[k] !== m_sr[k]) begin n_bad++;
                $display("FAIL rnd_status[%0d] cyc %0d got %h want %h", k, j, sr[k], m_sr[k]); end
            n_cmp++; if (fwd[k] !== m_fwd(k)) begin n_bad++;
                $display("FAIL rnd_fwd[%0d] cyc %0d got %h want %h", k, j, fwd[k], m_fwd(k)); end
            n_cmp++; if (haz[k] !== m_hazard(k)) begin n_bad++;
                $display("FAIL rnd_hazard[%0d] cyc %0d got %b want %b", k, j, haz[k], m_hazard(k)); end
            n_cmp++; if (cnt[k] !== 3'(m_q[k].size())) begin n_bad++;
                $display("FAIL rnd_count[%0d] cyc %0d got %0d want %0d", k, j, cnt[k], m_q[k].size()); end
            n_cmp++; if (perr[k] !== m_err[k]) begin n_bad++;
                $display("FAIL rnd_err[%0d] cyc %0d got %b want %b", k, j, perr[k], m_err[k]); end
            step(k);
        end
        idle(k);
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            idle(k);
            m_sr[k] = 4'h0; m_err[k] = 1'b0; m_adv[k] = 0;
        end
        @(negedge clk);
        for (int k = 0; k < NI; k++) test_reset(k);
        test_write_forward();
        test_noforward_stall();
        test_deep();
        test_flush_hold();
        test_protocol_err();
        for (int k = 0; k < NI; k++) test_random(k, 400);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
